btb_lookup: RTL and testbench

BTB_LOOKUP -- requirements
Module: btb_lookup

---
 rtl/btb_pkg.sv | 54 +++++
 rtl/btb_way_match.sv | 21 ++
 rtl/btb_lookup.sv | 155 +++++++++++++++
 tb/tb_btb_lookup.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared BTB definitions: way layout, branch-state encoding and geometry.
// Used by the lookup path, the write side and the predictor FSM.
package btb_pkg;

  localparam int NUM_SETS = 8;
  localparam int INDEX_W  = 3;
  localparam int TAG_W    = 27;
  localparam int TARGET_W = 32;
  localparam int STATE_W  = 2;
  localparam int WAY_W    = 64;
  localparam int SET_W    = 128;

  localparam int VALID_BIT  = 63;
  localparam int TAG_MSB    = 62;
  localparam int TAG_LSB    = 36;
  localparam int TARGET_MSB = 35;
  localparam int TARGET_LSB = 4;
  localparam int STATE_MSB  = 3;
  localparam int STATE_LSB  = 2;
  localparam int PAD_MSB    = 1;
  localparam int PAD_LSB    = 0;

  localparam int WAY1_MSB = 127;
  localparam int WAY1_LSB = 64;
  localparam int WAY2_MSB = 63;
  localparam int WAY2_LSB = 0;

  typedef enum logic [STATE_W-1:0] {
    STRONG_NOT_TAKEN = 2'b00,
    WEAK_NOT_TAKEN   = 2'b01,
    WEAK_TAKEN       = 2'b10,
    STRONG_TAKEN     = 2'b11
  } bp_state_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [TARGET_W-1:0] target;
    bp_state_t           state;
    logic [1:0]          pad;
  } btb_way_t;

  function automatic btb_way_t clear_pad(input btb_way_t w);
    btb_way_t r;
    r     = w;
    r.pad = 2'b00;
    return r;
  endfunction

  function automatic logic state_taken(input bp_state_t s);
    return s[1];
  endfunction

endpackage

// File: rtl/btb_way_match.sv
// Tag comparison for a single BTB way; unpacks target and branch state.
module btb_way_match
  import btb_pkg::*;
(
  input  logic [WAY_W-1:0]    way,
  input  logic [TAG_W-1:0]    tag,
  output logic                hit,
  output logic [TARGET_W-1:0] target,
  output bp_state_t           state
);

  btb_way_t way_s;
  logic     unused_pad;

  assign way_s      = btb_way_t'(way);
  assign hit        = way_s.valid & (way_s.tag == tag);
  assign target     = way_s.target;
  assign state      = way_s.state;
  assign unused_pad = ^way_s.pad;

endmodule

// File: rtl/btb_lookup.sv
// Two-way, eight-set branch target buffer lookup with registered prediction,
// per-set LRU tracking and same-cycle write-to-lookup bypass.
module btb_lookup
  import btb_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pc,
  input  logic                read_en,
  input  logic                stall,
  input  logic                flush,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [TARGET_W-1:0] pred_target,
  input  logic [INDEX_W-1:0]  update_index,
  output logic [SET_W-1:0]    update_set,
  output logic [NUM_SETS-1:0] lru,
  input  logic                write_en,
  input  logic [INDEX_W-1:0]  write_index,
  input  logic [SET_W-1:0]    write_set,
  input  logic                write_lru
);

  logic [SET_W-1:0]    sets_r [NUM_SETS];
  logic [NUM_SETS-1:0] lru_r;
  logic                pred_valid_r;
  logic                pred_taken_r;
  logic [TARGET_W-1:0] pred_target_r;

  logic [INDEX_W-1:0]  index_s;
  logic [TAG_W-1:0]    tag_s;
  logic                unused_pc;
  logic [SET_W-1:0]    lookup_set_s;
  logic                hit1_s;
  logic                hit2_s;
  logic [TARGET_W-1:0] target1_s;
  logic [TARGET_W-1:0] target2_s;
  bp_state_t           state1_s;
  bp_state_t           state2_s;
  logic                next_valid_s;
  logic                next_taken_s;
  logic [TARGET_W-1:0] next_target_s;
  logic                read_upd_s;
  logic [NUM_SETS-1:0] lru_next_s;

  assign index_s   = pc[4:2];
  assign tag_s     = pc[31:5];
  assign unused_pc = ^pc[1:0];

  // Lookup source: a write landing on the same set is forwarded to the compare.
  always_comb begin
    lookup_set_s = '0;
    if (write_en && (write_index == index_s)) begin
      lookup_set_s = write_set;
    end else begin
      lookup_set_s = sets_r[index_s];
    end
  end

  btb_way_match u_way1 (
    .way    (lookup_set_s[WAY1_MSB:WAY1_LSB]),
    .tag    (tag_s),
    .hit    (hit1_s),
    .target (target1_s),
    .state  (state1_s)
  );

  btb_way_match u_way2 (
    .way    (lookup_set_s[WAY2_MSB:WAY2_LSB]),
    .tag    (tag_s),
    .hit    (hit2_s),
    .target (target2_s),
    .state  (state2_s)
  );

  // Prediction candidate; way1 takes precedence when both ways match.
  always_comb begin
    next_valid_s  = 1'b0;
    next_taken_s  = 1'b0;
    next_target_s = '0;
    if (read_en && hit1_s) begin
      next_valid_s  = 1'b1;
      next_taken_s  = state_taken(state1_s);
      next_target_s = target1_s;
    end else if (read_en && hit2_s) begin
      next_valid_s  = 1'b1;
      next_taken_s  = state_taken(state2_s);
      next_target_s = target2_s;
    end else begin
      next_valid_s  = 1'b0;
      next_taken_s  = 1'b0;
      next_target_s = '0;
    end
  end

  // Next LRU vector: write-side update overrides the read-hit update on the same set.
  always_comb begin
    lru_next_s = lru_r;
    read_upd_s = read_en & ~stall & ~flush & (hit1_s | hit2_s);
    for (int i = 0; i < NUM_SETS; i++) begin
      if (write_en && (write_index == INDEX_W'(i))) begin
        lru_next_s[i] = write_lru;
      end else if (read_upd_s && (index_s == INDEX_W'(i))) begin
        lru_next_s[i] = ~hit1_s;
      end else begin
        lru_next_s[i] = lru_r[i];
      end
    end
  end

  // Prediction registers: flush beats stall beats capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_valid_r  <= 1'b0;
      pred_taken_r  <= 1'b0;
      pred_target_r <= '0;
    end else if (flush) begin
      pred_valid_r  <= 1'b0;
      pred_taken_r  <= 1'b0;
      pred_target_r <= '0;
    end else if (!stall) begin
      pred_valid_r  <= next_valid_s;
      pred_taken_r  <= next_taken_s;
      pred_target_r <= next_target_s;
    end
  end

  // LRU state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lru_r <= '0;
    end else begin
      lru_r <= lru_next_s;
    end
  end

  // Set storage; writes ignore stall and flush, pad bits are stored as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        sets_r[i] <= '0;
      end
    end else if (write_en) begin
      sets_r[write_index] <= {clear_pad(btb_way_t'(write_set[WAY1_MSB:WAY1_LSB])),
                              clear_pad(btb_way_t'(write_set[WAY2_MSB:WAY2_LSB]))};
    end
  end

  assign pred_valid  = pred_valid_r;
  assign pred_taken  = pred_taken_r;
  assign pred_target = pred_target_r;
  assign update_set  = sets_r[update_index];
  assign lru         = lru_r;

endmodule

// File: tb/tb_btb_lookup.sv
// Directed and randomized bench for btb_lookup against an array-based reference model.
module tb_btb_lookup;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  pc;
  logic         read_en, stall, flush;
  logic         pred_valid, pred_taken;
  logic [31:0]  pred_target;
  logic [2:0]   update_index;
  logic [127:0] update_set;
  logic [7:0]   lru;
  logic         write_en;
  logic [2:0]   write_index;
  logic [127:0] write_set;
  logic         write_lru;

  int checks = 0;
  int failures = 0;

  logic [127:0] m_sets [8];
  logic [7:0]   m_lru;
  logic         m_pv, m_pt;
  logic [31:0]  m_ptgt;
  logic [26:0]  pool [4];

  always #5 clk = ~clk;

  btb_lookup dut (
    .clk(clk), .rst(rst), .pc(pc), .read_en(read_en), .stall(stall), .flush(flush),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .update_index(update_index), .update_set(update_set), .lru(lru),
    .write_en(write_en), .write_index(write_index), .write_set(write_set),
    .write_lru(write_lru)
  );

  function automatic logic [63:0] mk(input logic v, input logic [26:0] t,
                                     input logic [31:0] tg, input logic [1:0] st);
    return {v, t, tg, st, 2'b00};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_sets[i] = 128'h0;
    m_lru = 8'h00; m_pv = 1'b0; m_pt = 1'b0; m_ptgt = 32'h0;
  endtask

  task automatic check_all(input string nm);
    chk({nm, "_pv"}, {127'h0, pred_valid}, {127'h0, m_pv});
    chk({nm, "_pt"}, {127'h0, pred_taken}, {127'h0, m_pt});
    chk({nm, "_tgt"}, {96'h0, pred_target}, {96'h0, m_ptgt});
    chk({nm, "_lru"}, {120'h0, lru}, {120'h0, m_lru});
    chk({nm, "_uset"}, update_set, m_sets[update_index]);
  endtask

  // One clock: predict from the rules using current inputs, advance, compare.
  task automatic step(input string nm);
    logic [2:0]   idx;
    logic [127:0] s;
    logic [63:0]  w1, w2, win;
    logic         h1, h2;
    idx = pc[4:2];
    s   = (write_en && write_index == idx) ? write_set : m_sets[idx];
    w1  = s[127:64];
    w2  = s[63:0];
    h1  = w1[63] && (w1[62:36] == pc[31:5]);
    h2  = w2[63] && (w2[62:36] == pc[31:5]);
    win = h1 ? w1 : w2;
    if (flush) begin
      m_pv = 1'b0; m_pt = 1'b0; m_ptgt = 32'h0;
    end else if (!stall) begin
      if (read_en && (h1 || h2)) begin
        m_pv = 1'b1; m_pt = win[3]; m_ptgt = win[35:4];
      end else begin
        m_pv = 1'b0; m_pt = 1'b0; m_ptgt = 32'h0;
      end
    end
    if (read_en && !stall && !flush && (h1 || h2)) m_lru[idx] = h1 ? 1'b0 : 1'b1;
    if (write_en) begin
      m_lru[write_index]  = write_lru;
      m_sets[write_index] = write_set;
    end
    @(posedge clk);
    #1;
    check_all(nm);
  endtask

  initial begin
    pool[0] = 27'h80; pool[1] = 27'h81; pool[2] = 27'h55; pool[3] = 27'h7ff_ffff;
    rst = 1'b1; pc = 32'h0; read_en = 1'b0; stall = 1'b0; flush = 1'b0;
    update_index = 3'd0; write_en = 1'b0; write_index = 3'd0;
    write_set = 128'h0; write_lru = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all("reset");

    // Lookup into an empty table misses.
    read_en = 1'b1; pc = 32'h0000_1000;
    step("empty_miss");
    chk("empty_pv_const", {127'h0, pred_valid}, 128'h0);

    // Install way1 at set 0, then hit on it.
    read_en = 1'b0; write_en = 1'b1; write_index = 3'd0; write_lru = 1'b1;
    write_set = {mk(1'b1, 27'h80, 32'h0000_2000, 2'b10), 64'h0};
    step("wr_way1");
    write_en = 1'b0; read_en = 1'b1; pc = 32'h0000_1000;
    step("hit_way1");
    chk("hit_way1_tgt_const", {96'h0, pred_target}, {96'h0, 32'h0000_2000});
    chk("hit_way1_lru0_const", {127'h0, lru[0]}, 128'h0);

    // Stall holds prediction and LRU even while the PC misses.
    stall = 1'b1; pc = 32'h0000_2000;
    for (int i = 0; i < 3; i++) step("stall_hold");
    chk("stall_tgt_const", {96'h0, pred_target}, {96'h0, 32'h0000_2000});
    flush = 1'b1;
    step("stall_flush");
    chk("flush_pv_const", {127'h0, pred_valid}, 128'h0);
    stall = 1'b0; flush = 1'b0;

    // Same-cycle write to the looked-up set is forwarded; write LRU wins.
    pc = 32'h0000_1000; write_en = 1'b1; write_index = 3'd0; write_lru = 1'b0;
    write_set = {mk(1'b0, 27'h80, 32'h0000_2000, 2'b10), mk(1'b1, 27'h80, 32'h0000_3000, 2'b01)};
    step("bypass");
    chk("bypass_tgt_const", {96'h0, pred_target}, {96'h0, 32'h0000_3000});
    chk("bypass_lru0_const", {127'h0, lru[0]}, 128'h0);

    // Both ways match: way1 wins.
    read_en = 1'b0; write_lru = 1'b1;
    write_set = {mk(1'b1, 27'h80, 32'h0000_4000, 2'b11), mk(1'b1, 27'h80, 32'h0000_5000, 2'b00)};
    step("wr_both");
    write_en = 1'b0; read_en = 1'b1;
    step("both_hit");
    chk("both_tgt_const", {96'h0, pred_target}, {96'h0, 32'h0000_4000});

    // Asynchronous reset between edges while a hit is registered.
    step("pre_rst_hit");
    #2 rst = 1'b1;
    #1;
    model_clear();
    chk("arst_pv", {127'h0, pred_valid}, 128'h0);
    chk("arst_lru", {120'h0, lru}, 128'h0);
    for (int j = 0; j < 8; j++) begin
      update_index = 3'(j);
      #1;
      chk("arst_uset", update_set, 128'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    update_index = 3'd0;
    step("post_rst_miss");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      read_en      = ($urandom_range(0, 3) != 0);
      pc           = {pool[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 2'b00};
      stall        = ($urandom_range(0, 7) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      write_en     = ($urandom_range(0, 2) == 0);
      write_index  = 3'($urandom_range(0, 7));
      write_lru    = 1'($urandom_range(0, 1));
      update_index = 3'($urandom_range(0, 7));
      write_set    = {mk(1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)], $urandom, 2'($urandom_range(0, 3))),
                      mk(1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)], $urandom, 2'($urandom_range(0, 3)))};
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
